// File: rtl/control_sequencer.sv
// Hardwired microsequencer driving the datapath control strobes (fetch/decode/execute).
// Optional ILLEGAL_TRAP_EN: opcodes B-E trap to HALT and raise sticky illegal_op.
module control_sequencer #(
  parameter logic [2:0] PC_SEL        = 3'd4,
  parameter bit         RESET_PC_HOLD = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic [2:0] ALU_control,
  output logic       GPR_in,
  output logic       GPR_out,
  output logic [2:0] GPR_select,
  output logic       IR_in,
  output logic       MAR_in,
  output logic       MDR_in,
  output logic       MDR_out,
  output logic       RAM_enable_read,
  output logic       RAM_enable_write,
  output logic       Y_in,
  output logic       Y_out,
  output logic       Y_offset_in,
  output logic       Z_in,
  output logic       Z_out,
  output logic       instr_done,
  output logic       halted,
  output logic [4:0] state_dbg
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_NOT   = 4'h6;
  localparam logic [3:0] OP_MOV   = 4'h7;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_BR    = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] ALU_NOT  = 3'd5;
  localparam logic [2:0] ALU_PASS = 3'd6;
  localparam logic [2:0] ALU_INC  = 3'd7;

  localparam logic [2:0] SEL_RD1 = 3'd0;
  localparam logic [2:0] SEL_RS1 = 3'd2;
  localparam logic [2:0] SEL_RS2 = 3'd3;

  typedef enum logic [4:0] {
    IDLE, FETCH0, FETCH1, FETCH2, DECODE,
    A0, A1, A2, L0, L1, L2, S0, S1, S2, HALT
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] op_q;
  logic       is_binary;

  assign is_binary = (op_q >= OP_ADD) && (op_q <= OP_XOR);
  assign halted    = (state == HALT) && !reset;
  assign state_dbg = state;

  // State and latched opcode; run low freezes everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET_PC_HOLD ? IDLE : FETCH0;
      op_q  <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_op <= 1'b0;
`endif
    end else if (run) begin
      state <= state_nxt;
      if (state == DECODE) op_q <= opcode;
`ifdef ILLEGAL_TRAP_EN
      if (state == DECODE && opcode >= 4'hB && opcode <= 4'hE) illegal_op <= 1'b1;
`endif
    end
  end

  // Next state and Moore strobes; strobes forced low while stalled or in reset
  always_comb begin
    state_nxt        = state;
    ALU_control      = '0;
    GPR_in           = 1'b0;
    GPR_out          = 1'b0;
    GPR_select       = '0;
    IR_in            = 1'b0;
    MAR_in           = 1'b0;
    MDR_in           = 1'b0;
    MDR_out          = 1'b0;
    RAM_enable_read  = 1'b0;
    RAM_enable_write = 1'b0;
    Y_in             = 1'b0;
    Y_out            = 1'b0;
    Y_offset_in      = 1'b0;
    Z_in             = 1'b0;
    Z_out            = 1'b0;
    instr_done       = 1'b0;

    case (state)
      IDLE:   state_nxt = FETCH0;
      FETCH0: begin
        GPR_out = 1'b1; GPR_select = PC_SEL; MAR_in = 1'b1;
        ALU_control = ALU_INC; Z_in = 1'b1;
        state_nxt = FETCH1;
      end
      FETCH1: begin
        RAM_enable_read = 1'b1; Z_out = 1'b1; GPR_in = 1'b1; GPR_select = PC_SEL;
        state_nxt = FETCH2;
      end
      FETCH2: begin
        MDR_out = 1'b1; IR_in = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: begin
        case (opcode) inside
          OP_NOP:                 begin state_nxt = FETCH0; instr_done = 1'b1; end
          [OP_ADD:OP_XOR]:        state_nxt = A0;
          OP_NOT, OP_MOV, OP_BR:  state_nxt = A1;
          OP_LOAD:                state_nxt = L0;
          OP_STORE:               state_nxt = S0;
          OP_HALT:                state_nxt = HALT;
`ifdef ILLEGAL_TRAP_EN
          default:                state_nxt = HALT;
`else
          default:                begin state_nxt = FETCH0; instr_done = 1'b1; end
`endif
        endcase
      end
      A0: begin
        GPR_out = 1'b1; GPR_select = SEL_RS1; Y_in = 1'b1;
        state_nxt = A1;
      end
      A1: begin
        GPR_out = 1'b1; Z_in = 1'b1;
        GPR_select = is_binary ? SEL_RS2 : SEL_RS1;
        if (is_binary)            ALU_control = 3'(op_q - OP_ADD);
        else if (op_q == OP_NOT)  ALU_control = ALU_NOT;
        else                      ALU_control = ALU_PASS;
        state_nxt = A2;
      end
      A2: begin
        Z_out = 1'b1; GPR_in = 1'b1; instr_done = 1'b1;
        GPR_select = (op_q == OP_BR) ? PC_SEL : SEL_RD1;
        state_nxt = FETCH0;
      end
      L0: begin
        GPR_out = 1'b1; GPR_select = SEL_RS1; MAR_in = 1'b1;
        state_nxt = L1;
      end
      L1: begin
        RAM_enable_read = 1'b1;
        state_nxt = L2;
      end
      L2: begin
        MDR_out = 1'b1; GPR_in = 1'b1; GPR_select = SEL_RD1; instr_done = 1'b1;
        state_nxt = FETCH0;
      end
      S0: begin
        GPR_out = 1'b1; GPR_select = SEL_RS1; MAR_in = 1'b1;
        state_nxt = S1;
      end
      S1: begin
        GPR_out = 1'b1; GPR_select = SEL_RS2; MDR_in = 1'b1;
        state_nxt = S2;
      end
      S2: begin
        RAM_enable_write = 1'b1; instr_done = 1'b1;
        state_nxt = FETCH0;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase

    if (reset || !run) begin
      ALU_control      = '0;
      GPR_in           = 1'b0;
      GPR_out          = 1'b0;
      GPR_select       = '0;
      IR_in            = 1'b0;
      MAR_in           = 1'b0;
      MDR_in           = 1'b0;
      MDR_out          = 1'b0;
      RAM_enable_read  = 1'b0;
      RAM_enable_write = 1'b0;
      Y_in             = 1'b0;
      Z_in             = 1'b0;
      Z_out            = 1'b0;
      instr_done       = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction micro-step table model, directed then random stimulus.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset, run;
  logic [3:0] opcode;
  logic [2:0] ALU_control, GPR_select;
  logic       GPR_in, GPR_out, IR_in, MAR_in, MDR_in, MDR_out;
  logic       RAM_enable_read, RAM_enable_write, Y_in, Y_out, Y_offset_in;
  logic       Z_in, Z_out, instr_done, halted;
  logic [4:0] state_dbg;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_op;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .ALU_control(ALU_control), .GPR_in(GPR_in), .GPR_out(GPR_out), .GPR_select(GPR_select),
    .IR_in(IR_in), .MAR_in(MAR_in), .MDR_in(MDR_in), .MDR_out(MDR_out),
    .RAM_enable_read(RAM_enable_read), .RAM_enable_write(RAM_enable_write),
    .Y_in(Y_in), .Y_out(Y_out), .Y_offset_in(Y_offset_in), .Z_in(Z_in), .Z_out(Z_out),
    .instr_done(instr_done), .halted(halted), .state_dbg(state_dbg)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  typedef struct packed {
    logic [2:0] alu;
    logic [2:0] sel;
    logic gin, gout, ir, mar, mdr_in, mdr_out, rd, wr, y_in, z_in, z_out, done;
  } step_t;

  step_t      exp_q[$];
  logic [3:0] plan_q[$];
  logic [3:0] cur_op;
  int         pos;
  bit         m_idle, m_halt, m_ill, prev_stall;
  int         stall_l1;
  logic [4:0] last_dbg;
  int         n_assert = 0;
  int         n_fail = 0;

  // Select code only matters with a GPR strobe, ALU code only when Z latches
  function automatic step_t mask(input step_t s);
    step_t t = s;
    if (!(t.gin || t.gout)) t.sel = '0;
    if (!t.z_in) t.alu = '0;
    return t;
  endfunction

  function automatic bit is_illegal(input logic [3:0] op);
    return op >= 4'hB && op <= 4'hE;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Expected micro-step list for one instruction, fetch included
  task automatic push_instr(input logic [3:0] op);
    step_t s;
    s = '0; s.gout = 1; s.sel = 3'd4; s.mar = 1; s.alu = 3'd7; s.z_in = 1; exp_q.push_back(s);
    s = '0; s.rd = 1; s.z_out = 1; s.gin = 1; s.sel = 3'd4;               exp_q.push_back(s);
    s = '0; s.mdr_out = 1; s.ir = 1;                                       exp_q.push_back(s);
    s = '0; s.done = (op == 4'h0) || (is_illegal(op) && !TRAP);            exp_q.push_back(s);
    if (op >= 4'h1 && op <= 4'h5) begin
      s = '0; s.gout = 1; s.sel = 3'd2; s.y_in = 1;                    exp_q.push_back(s);
      s = '0; s.gout = 1; s.sel = 3'd3; s.z_in = 1; s.alu = 3'(op - 4'd1); exp_q.push_back(s);
      s = '0; s.z_out = 1; s.gin = 1; s.sel = 3'd0; s.done = 1;        exp_q.push_back(s);
    end else if (op == 4'h6 || op == 4'h7 || op == 4'hA) begin
      s = '0; s.gout = 1; s.sel = 3'd2; s.z_in = 1; s.alu = (op == 4'h6) ? 3'd5 : 3'd6;
      exp_q.push_back(s);
      s = '0; s.z_out = 1; s.gin = 1; s.sel = (op == 4'hA) ? 3'd4 : 3'd0; s.done = 1;
      exp_q.push_back(s);
    end else if (op == 4'h8) begin
      s = '0; s.gout = 1; s.sel = 3'd2; s.mar = 1;                     exp_q.push_back(s);
      s = '0; s.rd = 1;                                                exp_q.push_back(s);
      s = '0; s.mdr_out = 1; s.gin = 1; s.sel = 3'd0; s.done = 1;      exp_q.push_back(s);
    end else if (op == 4'h9) begin
      s = '0; s.gout = 1; s.sel = 3'd2; s.mar = 1;                     exp_q.push_back(s);
      s = '0; s.gout = 1; s.sel = 3'd3; s.mdr_in = 1;                  exp_q.push_back(s);
      s = '0; s.wr = 1; s.done = 1;                                    exp_q.push_back(s);
    end
  endtask

  // One clock: drive at negedge, check after settle, advance the model for the next posedge
  task automatic cyc(input bit rst_v, input bit run_v);
    step_t e, o;
    bit    r;
    @(negedge clk);
    if (!rst_v && !m_idle && !m_halt && exp_q.size() == 0) begin
      cur_op = (plan_q.size() > 0) ? plan_q.pop_front() : 4'($urandom_range(0, 15));
      push_instr(cur_op);
      pos = 0;
    end
    r = run_v;
    if (!rst_v && !m_idle && !m_halt && cur_op == 4'h8 && pos == 5 && stall_l1 > 0) begin
      r = 1'b0;
      stall_l1--;
    end
    reset  = rst_v;
    run    = r;
    opcode = (pos == 3) ? cur_op : 4'($urandom_range(0, 15));
    #1;
    e = (rst_v || !r || m_idle || m_halt || exp_q.size() == 0) ? step_t'('0) : exp_q[0];
    o.alu = ALU_control;   o.sel = GPR_select;   o.gin = GPR_in;       o.gout = GPR_out;
    o.ir = IR_in;          o.mar = MAR_in;       o.mdr_in = MDR_in;    o.mdr_out = MDR_out;
    o.rd = RAM_enable_read; o.wr = RAM_enable_write; o.y_in = Y_in;   o.z_in = Z_in;
    o.z_out = Z_out;       o.done = instr_done;
    check("strobes", {13'b0, mask(o)}, {13'b0, mask(e)});
    check("y_out_offset", {30'b0, Y_out, Y_offset_in}, 32'd0);
    check("halted", {31'b0, halted}, {31'b0, m_halt && !rst_v});
    check("bus_single_driver",
          {31'b0, (2'(GPR_out) + 2'(MDR_out) + 2'(Z_out) + 2'(Y_out)) <= 2'd1 && !(GPR_in && GPR_out)},
          32'd1);
    if (prev_stall) check("stall_state_hold", {27'b0, state_dbg}, {27'b0, last_dbg});
`ifdef ILLEGAL_TRAP_EN
    check("illegal_op", {31'b0, illegal_op}, {31'b0, m_ill});
`endif
    last_dbg   = state_dbg;
    prev_stall = !r && !rst_v;
    if (rst_v) begin
      exp_q.delete();
      m_idle = 1'b1; m_halt = 1'b0; m_ill = 1'b0; pos = -1;
    end else if (r) begin
      if (m_idle) m_idle = 1'b0;
      else if (!m_halt) begin
        if (pos == 3 && TRAP && is_illegal(cur_op)) m_ill = 1'b1;
        void'(exp_q.pop_front());
        pos++;
        if (exp_q.size() == 0 && (cur_op == 4'hF || (TRAP && is_illegal(cur_op)))) m_halt = 1'b1;
      end
    end
  endtask

  // Run until the planned instructions retire, bounded
  task automatic drain(input int budget);
    int n = 0;
    while ((plan_q.size() > 0 || exp_q.size() > 0 || m_idle) && n < budget) begin
      cyc(1'b0, 1'b1);
      n++;
    end
    check("drain_within_budget", {31'b0, n < budget}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; opcode = '0;
    m_idle = 1'b1; m_halt = 1'b0; m_ill = 1'b0; pos = -1; stall_l1 = 0;
    prev_stall = 1'b0; last_dbg = '0; cur_op = '0;

    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);

    // ADD, STORE, BR, NOP back to back
    plan_q.push_back(4'h1); plan_q.push_back(4'h9);
    plan_q.push_back(4'hA); plan_q.push_back(4'h0);
    drain(100);

    // LOAD with a three-cycle stall in L1, then MOV/NOT/SUB/XOR
    stall_l1 = 3;
    plan_q.push_back(4'h8); plan_q.push_back(4'h7); plan_q.push_back(4'h6);
    plan_q.push_back(4'h2); plan_q.push_back(4'h5);
    drain(100);

    // HALT holds, reset releases it
    plan_q.push_back(4'hF);
    drain(50);
    repeat (12) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);

    // Illegal opcode: NOP-like by default, trap when enabled
    plan_q.push_back(4'hC); plan_q.push_back(4'h3);
    drain(50);
    repeat (4) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);

    // Random opcodes, run drops and occasional mid-instruction reset
    repeat (800) cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired microsequencer that generates the per-cycle datapath control strobes for the bus-based CPU: GPR file, IR, MAR, MDR, RAM, Y, the ALU and the Z register. It decodes the IR opcode and walks fetch, decode and execute micro-steps. It is the driving end of the control-signal interface that the datapath consumes. One micro-step is executed per clk edge; in the top level, clk is driven by the one-shot clock.

Parameters:
PC_SEL, 3'd4, GPR_select code addressing R7 as program counter
RESET_PC_HOLD, 1, when 1 the first fetch after reset waits one idle cycle

Ports:
clk  in  1  system clock (one-shot pulse clock in top level)
reset  in  1  synchronous, active-high
run  in  1  advance enable; low freezes the state and drives all strobes to 0
opcode  in  4  IR opcode field
ALU_control  out  3  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOT,6 PASS,7 INC
GPR_in  out  1  write selected GPR from bus
GPR_out  out  1  drive selected GPR onto bus
GPR_select  out  3  0 Rd_1,1 Rd_2,2 Rs_1,3 Rs_2,PC_SEL = PC
IR_in  out  1  latch bus into IR
MAR_in  out  1  latch bus into MAR
MDR_in  out  1  latch bus into MDR
MDR_out  out  1  MDR drives bus
RAM_enable_read  out  1  RAM to MDR transfer
RAM_enable_write  out  1  MDR to RAM transfer
Y_in  out  1  latch bus into Y
Y_out  out  1  Y drives bus (held 0 by this block)
Y_offset_in  out  1  reserved, held 0
Z_in  out  1  latch ALU result into Z
Z_out  out  1  Z drives bus
instr_done  out  1  one-cycle pulse on the final micro-step of each instruction
halted  out  1  high while in HALT
state_dbg  out  5  current state encoding, for LED/debug

Behaviour:
- State register only. Strobes are Moore outputs decoded from state, gated by run and by ~reset.
- Reset (sync): state <= IDLE. While reset or ~run, every strobe, instr_done and ALU_control are 0. halted is 0 after reset.
- IDLE -> FETCH0. When RESET_PC_HOLD=0, reset goes directly to FETCH0.
- FETCH0: GPR_out, sel=PC, MAR_in, ALU_control=INC, Z_in -> FETCH1.
- FETCH1: RAM_enable_read, Z_out, GPR_in, sel=PC -> FETCH2.
- FETCH2: MDR_out, IR_in -> DECODE.
- DECODE: no strobes. Branch on opcode, which is sampled this cycle, when IR is valid:
  - 0 NOP -> FETCH0, instr_done.
  - 1-5 (ADD/SUB/AND/OR/XOR) -> A0.
  - 6 NOT, 7 MOV -> A1.
  - 8 LOAD -> L0.
  - 9 STORE -> S0.
  - A BR -> A1 with PASS, destination PC.
  - F HALT -> HALT.
  - B-E are illegal; see Optional Feature.
- A0: GPR_out sel=Rs_1, Y_in -> A1.
- A1: GPR_out with sel=Rs_2 for binary ops, else Rs_1. Z_in. ALU_control = ADD..XOR for opcodes 1-5, NOT for 6, PASS for 7 and A -> A2.
- A2: Z_out, GPR_in with sel=Rd_1, or PC for BR. instr_done -> FETCH0.
- L0: GPR_out sel=Rs_1, MAR_in -> L1.
- L1: RAM_enable_read -> L2.
- L2: MDR_out, GPR_in sel=Rd_1, instr_done -> FETCH0.
- S0: GPR_out sel=Rs_1, MAR_in -> S1.
- S1: GPR_out sel=Rs_2, MDR_in -> S2.
- S2: RAM_enable_write, instr_done -> FETCH0.
- HALT: halted=1, no strobes, self-loop until reset.
- Invariant: at most one of GPR_out/MDR_out/Z_out/Y_out is high in any cycle. GPR_in and GPR_out are never both high.
- The opcode latched at DECODE is held in an internal register. Execute states use that copy, so IR changes mid-instruction have no effect.
- Reset mid-instruction: abandon immediately. The next cycle is IDLE with all strobes 0.
- run low mid-instruction: the state holds. Resuming continues at the same micro-step.
- Latencies in cycles including fetch: NOP 4, ALU/MOV/BR 6 or 7, LOAD/STORE 7.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: opcodes B-E go to HALT and set sticky output illegal_op (1 bit, cleared only by reset). The illegal_op port exists only when the macro is defined.
- Undefined: opcodes B-E behave as NOP, with instr_done in DECODE.

Test Plan:
- Reset, then run=1 for 3 cycles -> IDLE, then FETCH0 strobes {GPR_out, MAR_in, Z_in, ALU_control=7, sel=4}, then FETCH1 {RAM_enable_read, Z_out, GPR_in, sel=4}.
- opcode=1 (ADD) -> A0 Y_in sel=2, A1 sel=3 ALU_control=0 Z_in, A2 GPR_in sel=0, instr_done on the 7th cycle after FETCH0 entry... exactly 1 pulse.
- opcode=9 (STORE) -> S0 MAR_in sel=2, S1 MDR_in sel=3, S2 RAM_enable_write=1 for exactly one cycle. No bus-driver overlap in any cycle (checked by assertion).
- opcode=A (BR) -> A1 ALU_control=6 sel=2, A2 GPR_in sel=4.
- Drop run for 3 cycles during L1 -> all strobes 0 and state_dbg constant. On resume, L1 repeats and then L2.
- opcode=F -> halted=1, strobes 0 for 10+ cycles. Assert reset -> halted=0, state IDLE. With ILLEGAL_TRAP_EN, opcode=C -> halted=1, illegal_op=1. Without it, -> FETCH0.
